sccb_init_sequencer: RTL

Sequences the camera configuration through the SCCB master. It drives the camera power-down and reset pins and waits out power-up. It then walks an external register table (ROM), issuing one SCCB 3-phase write per entry, handling delay and end markers, retrying on NACK and reporting completion or failure. It sits between the fabric reset/clock (CCC GL0 clock) and the SCCB master block.

---
 rtl/sccb_init_sequencer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/sccb_init_sequencer.sv
// Camera bring-up sequencer: drives power-down/reset pins, waits out power-up,
// then replays a register table through the SCCB master with delay/end markers and NACK retry.
module sccb_init_sequencer #(
  parameter int         CLKS_PER_MS = 25000,
  parameter int         ROM_AW      = 8,
  parameter logic [7:0] DEV_ADDR    = 8'h42,
  parameter int         RST_MS      = 2,
  parameter int         PWRUP_MS    = 10,
  parameter int         MAX_RETRY   = 3
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [7:0]        cmd_id,
  output logic [7:0]        cmd_reg,
  output logic [7:0]        cmd_val,
  input  logic              xfer_done,
  input  logic              xfer_nack,
  output logic              cam_rst_n,
  output logic              cam_pwdn,
  output logic              busy,
  output logic              init_done,
  output logic              init_err,
  output logic [ROM_AW-1:0] err_index
);

  localparam int                CW        = $clog2(CLKS_PER_MS);
  localparam int                RW        = $clog2(MAX_RETRY + 2);
  localparam logic [ROM_AW-1:0] LAST_ADDR = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_HWRST, S_PWRUP, S_FETCH, S_DECODE,
    S_DELAY, S_ISSUE, S_WAIT, S_DONE, S_ERROR
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cyc, w_cyc_nxt;
  logic [7:0]        r_ms, w_ms_nxt;
  logic [7:0]        r_dly_ms, w_dly_ms_nxt;
  logic [RW-1:0]     r_retry, w_retry_nxt;
  logic [ROM_AW-1:0] r_rom_addr, w_rom_addr_nxt;
  logic [ROM_AW-1:0] r_err_index, w_err_index_nxt;
  logic [7:0]        r_cmd_reg, w_cmd_reg_nxt;
  logic [7:0]        r_cmd_val, w_cmd_val_nxt;
  logic              r_cmd_valid, w_cmd_valid_nxt;
  logic              r_cam_rst_n, w_cam_rst_n_nxt;
  logic              r_cam_pwdn, w_cam_pwdn_nxt;
  logic              r_init_done, w_init_done_nxt;
  logic              r_init_err, w_init_err_nxt;

  logic       w_tick;
  logic [8:0] w_ms_inc;
  logic       w_timed;
  logic       w_adv;

  // One ms tick per wrap of the cycle counter; w_ms_inc is the ms count after this tick.
  assign w_tick   = (r_cyc == CW'(CLKS_PER_MS - 1));
  assign w_ms_inc = {1'b0, r_ms} + 9'd1;
  assign w_timed  = (r_state == S_HWRST) || (r_state == S_PWRUP) || (r_state == S_DELAY);

  always_comb begin
    // NOTE: every next-state value gets a hold default first, so no latch is inferred.
    w_state_nxt      = r_state;
    w_cyc_nxt        = w_timed ? (w_tick ? '0 : r_cyc + CW'(1)) : '0;
    w_ms_nxt         = (w_timed && w_tick) ? r_ms + 8'd1 : r_ms;
    w_dly_ms_nxt     = r_dly_ms;
    w_retry_nxt      = r_retry;
    w_rom_addr_nxt   = r_rom_addr;
    w_err_index_nxt  = r_err_index;
    w_cmd_reg_nxt    = r_cmd_reg;
    w_cmd_val_nxt    = r_cmd_val;
    w_cmd_valid_nxt  = r_cmd_valid;
    w_cam_rst_n_nxt  = r_cam_rst_n;
    w_cam_pwdn_nxt   = r_cam_pwdn;
    w_init_done_nxt  = r_init_done;
    w_init_err_nxt   = r_init_err;
    w_adv            = 1'b0;

    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          w_state_nxt     = S_HWRST;
          w_init_done_nxt = 1'b0;
          w_init_err_nxt  = 1'b0;
          w_err_index_nxt = '0;
          w_rom_addr_nxt  = '0;
          w_cam_pwdn_nxt  = 1'b0;
          w_cam_rst_n_nxt = 1'b0;
        end
      end
      S_HWRST: begin
        if (w_tick && (w_ms_inc == 9'(RST_MS))) begin
          w_state_nxt     = S_PWRUP;
          w_cam_rst_n_nxt = 1'b1;
        end
      end
      S_PWRUP: begin
        if (w_tick && (w_ms_inc == 9'(PWRUP_MS))) w_state_nxt = S_FETCH;
      end
      S_FETCH: w_state_nxt = S_DECODE;
      S_DECODE: begin
        if (rom_data == 16'hFFFF) begin
          w_state_nxt     = S_DONE;
          w_init_done_nxt = 1'b1;
        end else if (rom_data[15:8] == 8'hF0) begin
          w_state_nxt  = S_DELAY;
          w_dly_ms_nxt = rom_data[7:0];
        end else begin
          w_state_nxt     = S_ISSUE;
          w_cmd_reg_nxt   = rom_data[15:8];
          w_cmd_val_nxt   = rom_data[7:0];
          w_retry_nxt     = '0;
          w_cmd_valid_nxt = 1'b1;
        end
      end
      S_DELAY: begin
        w_adv = (r_dly_ms == 8'd0) || (w_tick && (w_ms_inc == {1'b0, r_dly_ms}));
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          w_state_nxt     = S_WAIT;
          w_cmd_valid_nxt = 1'b0;
        end
      end
      S_WAIT: begin
        if (xfer_done) begin
          if (!xfer_nack) begin
            w_adv = 1'b1;
          end else if (r_retry != RW'(MAX_RETRY)) begin
            w_state_nxt     = S_ISSUE;
            w_retry_nxt     = r_retry + RW'(1);
            w_cmd_valid_nxt = 1'b1;
          end else begin
            w_state_nxt     = S_ERROR;
            w_init_err_nxt  = 1'b1;
            w_err_index_nxt = r_rom_addr;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Finishing the last table slot without an end marker is an error, never a wrap to 0.
    if (w_adv) begin
      if (r_rom_addr == LAST_ADDR) begin
        w_state_nxt     = S_ERROR;
        w_init_err_nxt  = 1'b1;
        w_err_index_nxt = r_rom_addr;
      end else begin
        w_state_nxt    = S_FETCH;
        w_rom_addr_nxt = r_rom_addr + ROM_AW'(1);
      end
    end

    if (w_state_nxt != r_state) begin
      w_cyc_nxt = '0;
      w_ms_nxt  = '0;
    end
  end

  // NOTE: all state updates are non-blocking so every register samples pre-edge values.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state     <= S_IDLE;
      r_cyc       <= '0;
      r_ms        <= '0;
      r_dly_ms    <= '0;
      r_retry     <= '0;
      r_rom_addr  <= '0;
      r_err_index <= '0;
      r_cmd_reg   <= '0;
      r_cmd_val   <= '0;
      r_cmd_valid <= 1'b0;
      r_cam_rst_n <= 1'b0;
      r_cam_pwdn  <= 1'b1;
      r_init_done <= 1'b0;
      r_init_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cyc       <= w_cyc_nxt;
      r_ms        <= w_ms_nxt;
      r_dly_ms    <= w_dly_ms_nxt;
      r_retry     <= w_retry_nxt;
      r_rom_addr  <= w_rom_addr_nxt;
      r_err_index <= w_err_index_nxt;
      r_cmd_reg   <= w_cmd_reg_nxt;
      r_cmd_val   <= w_cmd_val_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      r_cam_rst_n <= w_cam_rst_n_nxt;
      r_cam_pwdn  <= w_cam_pwdn_nxt;
      r_init_done <= w_init_done_nxt;
      r_init_err  <= w_init_err_nxt;
    end
  end

  assign rom_addr  = r_rom_addr;
  assign cmd_valid = r_cmd_valid;
  assign cmd_id    = DEV_ADDR;
  assign cmd_reg   = r_cmd_reg;
  assign cmd_val   = r_cmd_val;
  assign cam_rst_n = r_cam_rst_n;
  assign cam_pwdn  = r_cam_pwdn;
  assign busy      = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);
  assign init_done = r_init_done;
  assign init_err  = r_init_err;
  assign err_index = r_err_index;

endmodule
